// File: rtl/io_word_arbiter_pkg.sv
// Shared types and constants for the io_word_arbiter pad-field arbiter.
package io_word_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam int WORD_W_DEF = 16;
    localparam int STAT_W_DEF = 4;
    localparam int HOLD_W_DEF = 16;

    // Bit positions of the checkword and status fields on mprj_io.
    localparam int CHECK_LSB  = 16;
    localparam int STATUS_LSB = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_word_arbiter_if.sv
// Requester handshake and pad-drive bundle of io_word_arbiter.
interface io_word_arbiter_if
    import io_word_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = WORD_W_DEF,
    parameter int STAT_W = STAT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) ();
    localparam int IDX_W = idx_width(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ*WORD_W-1:0]   req_word;
    logic [NREQ*STAT_W-1:0]   req_status;
    logic [NREQ-1:0]          req_ready;
    logic [HOLD_W-1:0]        hold_cycles;
    logic [WORD_W-1:0]        io_word;
    logic [STAT_W-1:0]        io_status;
    logic [WORD_W+STAT_W-1:0] io_oeb;
    logic                     busy;
    logic [IDX_W-1:0]         grant_id;

    modport master (
        output req_valid, req_word, req_status, hold_cycles,
        input  req_ready, io_word, io_status, io_oeb, busy, grant_id
    );

    modport slave (
        input  req_valid, req_word, req_status, hold_cycles,
        output req_ready, io_word, io_status, io_oeb, busy, grant_id
    );
endinterface

// File: rtl/io_word_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping.
module rr_pick
    import io_word_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NREQ);

    logic [IDX_W:0]   w_sum  [NREQ];
    logic [IDX_W-1:0] w_cand [NREQ];
    logic [NREQ-1:0]  w_hit;

    // Candidate gi is the requester at distance gi from the pointer.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
        assign w_cand[gi] = (w_sum[gi] >= NREQ_L) ? IDX_W'(w_sum[gi] - NREQ_L)
                                                   : IDX_W'(w_sum[gi]);
        assign w_hit[gi]  = i_req[w_cand[gi]];
    end

    always_comb begin
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

    assign o_any = |i_req;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign o_grant[gi] = o_any && (o_idx == IDX_W'(gi));
    end
endmodule

// File: rtl/io_word_arbiter.sv
// Round-robin arbiter driving one accepted checkword/status onto the pads for a hold time.
// Optional macro IO_WORD_ARB_OVERRIDE_EN makes requester 0 a pre-empting management override.
module io_word_arbiter
    import io_word_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = WORD_W_DEF,
    parameter int STAT_W = STAT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    io_word_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(NREQ);
    localparam int PAD_W = WORD_W + STAT_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_id;
    logic [HOLD_W-1:0]   r_cnt;
    logic [WORD_W-1:0]   r_io_word;
    logic [STAT_W-1:0]   r_io_status;
    logic [PAD_W-1:0]    r_io_oeb;

    logic [WORD_W-1:0]   w_words [NREQ];
    logic [STAT_W-1:0]   w_stats [NREQ];
    logic [IDX_W-1:0]    w_pick_ptr;
    logic [NREQ-1:0]     w_pick_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [IDX_W-1:0]    w_ptr_inc;
    logic                w_ptr_keep;
    logic                w_preempt;
    logic                w_accept;
    logic [HOLD_W-1:0]   w_cnt_load;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_words[gi] = bus.req_word[gi*WORD_W +: WORD_W];
        assign w_stats[gi] = bus.req_status[gi*STAT_W +: STAT_W];
    end

`ifdef IO_WORD_ARB_OVERRIDE_EN
    // Forcing the search origin to 0 makes requester 0 win whenever it is valid.
    assign w_pick_ptr = bus.req_valid[0] ? '0 : r_rr_ptr;
    assign w_ptr_keep = bus.req_valid[0];
    assign w_preempt  = bus.req_valid[0] && (r_grant_id != '0);
`else
    assign w_pick_ptr = r_rr_ptr;
    assign w_ptr_keep = 1'b0;
    assign w_preempt  = 1'b0;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_accept   = (r_state == ST_IDLE) && w_pick_any;
    assign w_ptr_inc  = (w_pick_idx == IDX_W'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
    assign w_cnt_load = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - 1'b1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_io_word   <= '0;
            r_io_status <= '0;
            r_io_oeb    <= '1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_io_word   <= w_words[w_pick_idx];
                r_io_status <= w_stats[w_pick_idx];
                r_grant_id  <= w_pick_idx;
                r_cnt       <= w_cnt_load;
                r_io_oeb    <= '0;
                if (!w_ptr_keep) begin
                    r_rr_ptr <= w_ptr_inc;
                end
            end else if ((r_state == ST_DRIVE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_any) w_state_next = ST_DRIVE;
            ST_DRIVE: if ((r_cnt == '0) || w_preempt) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state == ST_DRIVE);
        bus.req_ready = '0;
        if (w_accept && !wb_rst_i) begin
            bus.req_ready = w_pick_grant;
        end
    end

    assign bus.io_word   = r_io_word;
    assign bus.io_status = r_io_status;
    assign bus.io_oeb    = r_io_oeb;
    assign bus.grant_id  = r_grant_id;
endmodule
